// File: rtl/matmul_pkg.sv
// Shared types and sizes for the matrix memory responder and its row storage.
// Matrix geometry, responder state encoding and host select codes.
package matmul_pkg;

    localparam int ROW_W = 1024;
    localparam int ROWS  = 32;
    localparam int AW    = $clog2(ROWS);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WR_C,
        HOLD
    } resp_state_t;

    // Which request the current transaction belongs to; HOLD waits on that line only.
    typedef enum logic [1:0] {
        SVC_A,
        SVC_B,
        SVC_C
    } svc_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_C    = 2'b11;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(ROWS - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/row_ram.sv
// ROWS x ROW_W row storage: one write port and two independent synchronous read ports.
// Read registers are reset so the outputs built from them come up as zero.
module row_ram
    import matmul_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [ROW_W-1:0] wdata_i,
    input  logic             re0_i,
    input  logic [AW-1:0]    raddr0_i,
    output logic [ROW_W-1:0] rdata0_o,
    input  logic             re1_i,
    input  logic [AW-1:0]    raddr1_i,
    output logic [ROW_W-1:0] rdata1_o
);

    logic [ROW_W-1:0] mem_q [ROWS];
    logic [ROW_W-1:0] rdata0_q;
    logic [ROW_W-1:0] rdata1_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads sample the array before a same-edge write lands, so they return old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (re0_i) begin
                rdata0_q <= mem_q[raddr0_i];
            end
            if (re1_i) begin
                rdata1_q <= mem_q[raddr1_i];
            end
        end
    end

    assign rdata0_o = rdata0_q;
    assign rdata1_o = rdata1_q;

endmodule

// File: rtl/matrix_mem_responder.sv
// Memory-side responder for the accelerator fetch_A / fetch_B / store_C handshake.
// Request/ready: requests are levels; each accepted request gets exactly one 1-cycle ready pulse, then HOLD waits for that request to drop.
module matrix_mem_responder
    import matmul_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             fetch_A,
    input  logic             fetch_B,
    input  logic             store_C,
    input  logic [ROW_W-1:0] dataC_in,
    output logic             fetch_A_ready,
    output logic             fetch_B_ready,
    output logic             store_C_ready,
    output logic [ROW_W-1:0] data_out,
    input  logic             host_we,
    input  logic [1:0]       host_sel,
    input  logic [AW-1:0]    host_addr,
    input  logic [ROW_W-1:0] host_wdata,
    output logic [ROW_W-1:0] host_rdata,
    output logic             busy,
    output logic             host_err,
    output resp_state_t      dbg_state
);

    localparam int            CW       = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(READ_LAT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(READ_LAT - 2);
    localparam bit            LAT1     = (READ_LAT == 1);

    resp_state_t   state_q, state_d;
    svc_t          svc_q, svc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] ptr_a_q, ptr_a_d;
    logic [AW-1:0] ptr_b_q, ptr_b_d;
    logic [AW-1:0] ptr_c_q, ptr_c_d;
    logic          src_b_q, src_b_d;
    logic [1:0]    sel_q;
    logic          host_err_q, host_err_d;

    logic          re_a, re_b, c_we, a_we, b_we, host_ok;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [ROW_W-1:0] a_rd0, b_rd0, a_rd1, b_rd1, c_rd1, c_rd0_unused;

    always_comb begin
        state_d       = state_q;
        svc_d         = svc_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        ptr_a_d       = ptr_a_q;
        ptr_b_d       = ptr_b_q;
        ptr_c_d       = ptr_c_q;
        src_b_d       = src_b_q;
        re_a          = 1'b0;
        re_b          = 1'b0;
        c_we          = 1'b0;
        fetch_A_ready = 1'b0;
        fetch_B_ready = 1'b0;
        store_C_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (store_C) begin
                    c_we    = 1'b1;
                    svc_d   = SVC_C;
                    state_d = WR_C;
                end else if (fetch_A) begin
                    svc_d   = SVC_A;
                    addr_d  = ptr_a_q;
                    cnt_d   = '0;
                    re_a    = LAT1;
                    state_d = RD_A;
                end else if (fetch_B) begin
                    svc_d   = SVC_B;
                    addr_d  = ptr_b_q;
                    cnt_d   = '0;
                    re_b    = LAT1;
                    state_d = RD_B;
                end
            end
            RD_A: begin
                if (cnt_q == CNT_LAST) begin
                    fetch_A_ready = 1'b1;
                    ptr_a_d       = next_ptr(ptr_a_q);
                    state_d       = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    re_a  = (cnt_q == CNT_PRE);
                end
            end
            RD_B: begin
                if (cnt_q == CNT_LAST) begin
                    fetch_B_ready = 1'b1;
                    ptr_b_d       = next_ptr(ptr_b_q);
                    state_d       = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    re_b  = (cnt_q == CNT_PRE);
                end
            end
            WR_C: begin
                store_C_ready = 1'b1;
                ptr_c_d       = next_ptr(ptr_c_q);
                state_d       = HOLD;
            end
            HOLD: begin
                case (svc_q)
                    SVC_A:   if (!fetch_A) state_d = IDLE;
                    SVC_B:   if (!fetch_B) state_d = IDLE;
                    default: if (!store_C) state_d = IDLE;
                endcase
            end
            default: state_d = IDLE;
        endcase

        // start wins over a same-cycle pointer advance; an in-flight read keeps addr_q.
        if (start) begin
            ptr_a_d = '0;
            ptr_b_d = '0;
            ptr_c_d = '0;
        end

        // data_out switches source only on the edge that loads the new row.
        if (re_a) src_b_d = 1'b0;
        if (re_b) src_b_d = 1'b1;
    end

    assign rd_addr_a = (state_q == IDLE) ? ptr_a_q : addr_q;
    assign rd_addr_b = (state_q == IDLE) ? ptr_b_q : addr_q;

    assign host_ok    = (state_q == IDLE) && !(store_C || fetch_A || fetch_B) &&
                        ((host_sel == SEL_A) || (host_sel == SEL_B));
    assign a_we       = host_we && host_ok && (host_sel == SEL_A);
    assign b_we       = host_we && host_ok && (host_sel == SEL_B);
    assign host_err_d = host_we && !host_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            svc_q      <= SVC_A;
            cnt_q      <= '0;
            addr_q     <= '0;
            ptr_a_q    <= '0;
            ptr_b_q    <= '0;
            ptr_c_q    <= '0;
            src_b_q    <= 1'b0;
            sel_q      <= SEL_NONE;
            host_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            svc_q      <= svc_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            ptr_a_q    <= ptr_a_d;
            ptr_b_q    <= ptr_b_d;
            ptr_c_q    <= ptr_c_d;
            src_b_q    <= src_b_d;
            sel_q      <= host_sel;
            host_err_q <= host_err_d;
        end
    end

    row_ram u_ram_a (
        .clk(clk), .rst_n(rst_n),
        .we_i(a_we), .waddr_i(host_addr), .wdata_i(host_wdata),
        .re0_i(re_a), .raddr0_i(rd_addr_a), .rdata0_o(a_rd0),
        .re1_i(host_sel == SEL_A), .raddr1_i(host_addr), .rdata1_o(a_rd1)
    );

    row_ram u_ram_b (
        .clk(clk), .rst_n(rst_n),
        .we_i(b_we), .waddr_i(host_addr), .wdata_i(host_wdata),
        .re0_i(re_b), .raddr0_i(rd_addr_b), .rdata0_o(b_rd0),
        .re1_i(host_sel == SEL_B), .raddr1_i(host_addr), .rdata1_o(b_rd1)
    );

    // C is only ever read by the host; its responder port is idle.
    row_ram u_ram_c (
        .clk(clk), .rst_n(rst_n),
        .we_i(c_we), .waddr_i(ptr_c_q), .wdata_i(dataC_in),
        .re0_i(1'b0), .raddr0_i(ptr_c_q), .rdata0_o(c_rd0_unused),
        .re1_i(host_sel == SEL_C), .raddr1_i(host_addr), .rdata1_o(c_rd1)
    );

    always_comb begin
        host_rdata = '0;
        case (sel_q)
            SEL_A:   host_rdata = a_rd1;
            SEL_B:   host_rdata = b_rd1;
            SEL_C:   host_rdata = c_rd1;
            default: host_rdata = '0;
        endcase
    end

    assign data_out  = src_b_q ? b_rd0 : a_rd0;
    assign busy      = (state_q != IDLE);
    assign host_err  = host_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Self-checking bench for matrix_mem_responder: row fetches, C stores, host port and reset/start behaviour.
module tb_matrix_mem_responder;
    import matmul_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             fetch_A = 1'b0;
    logic             fetch_B = 1'b0;
    logic             store_C = 1'b0;
    logic [ROW_W-1:0] dataC_in = '0;
    logic             fetch_A_ready, fetch_B_ready, store_C_ready;
    logic [ROW_W-1:0] data_out;
    logic             host_we = 1'b0;
    logic [1:0]       host_sel = 2'b00;
    logic [AW-1:0]    host_addr = '0;
    logic [ROW_W-1:0] host_wdata = '0;
    logic [ROW_W-1:0] host_rdata;
    logic             busy, host_err;
    resp_state_t      dbg_state;

    always #5 clk = ~clk;

    matrix_mem_responder #(.READ_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .fetch_A(fetch_A), .fetch_B(fetch_B), .store_C(store_C), .dataC_in(dataC_in),
        .fetch_A_ready(fetch_A_ready), .fetch_B_ready(fetch_B_ready), .store_C_ready(store_C_ready),
        .data_out(data_out),
        .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .busy(busy), .host_err(host_err), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [ROW_W-1:0] exp_q[$];
    logic [ROW_W-1:0] a_m[ROWS];
    logic [ROW_W-1:0] b_m[ROWS];
    logic [ROW_W-1:0] c_m[ROWS];
    int pa = 0, pb = 0, pc = 0;
    int a_pulses = 0, b_pulses = 0, c_pulses = 0;

    task automatic check_val(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h (low 64 bits)", tag, got[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [ROW_W-1:0] fill(input logic [31:0] v);
        return {(ROW_W/32){v}};
    endfunction

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        for (int i = 0; i < ROW_W/32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Scoreboard: every fetch ready pulse pops one expected row.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fetch_A_ready) a_pulses++;
            if (fetch_B_ready) b_pulses++;
            if (store_C_ready) c_pulses++;
            if (fetch_A_ready || fetch_B_ready) begin
                if (exp_q.size() == 0) check_val("unexpected_ready", ROW_W'(1), ROW_W'(0));
                else check_val("data_out", data_out, exp_q.pop_front());
            end
        end
    end

    task automatic host_write(input logic [1:0] sel, input int addr, input logic [ROW_W-1:0] data,
                              input logic exp_err);
        @(negedge clk);
        host_we = 1'b1; host_sel = sel; host_addr = AW'(addr); host_wdata = data;
        @(negedge clk);
        host_we = 1'b0; host_sel = SEL_NONE;
        check_val("host_err", ROW_W'(host_err), ROW_W'(exp_err));
        if (!exp_err && sel == SEL_A) a_m[addr] = data;
        if (!exp_err && sel == SEL_B) b_m[addr] = data;
    endtask

    task automatic host_read(input string tag, input logic [1:0] sel, input int addr,
                             input logic [ROW_W-1:0] exp);
        @(negedge clk);
        host_sel = sel; host_addr = AW'(addr);
        @(negedge clk);
        check_val(tag, host_rdata, exp);
        host_sel = SEL_NONE;
    endtask

    task automatic wait_ready(input int which, output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if ((which == 0 && fetch_A_ready) || (which == 1 && fetch_B_ready) ||
                (which == 2 && store_C_ready)) return;
        end
        lat = 99;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check_val("idle", ROW_W'(busy), ROW_W'(0));
    endtask

    task automatic do_fetch(input bit is_b, input int extra);
        int lat;
        if (is_b) begin exp_q.push_back(b_m[pb]); pb = (pb + 1) % ROWS; end
        else      begin exp_q.push_back(a_m[pa]); pa = (pa + 1) % ROWS; end
        @(negedge clk);
        if (is_b) fetch_B = 1'b1; else fetch_A = 1'b1;
        wait_ready(int'(is_b), lat);
        check_val(is_b ? "lat_b" : "lat_a", ROW_W'(lat), ROW_W'(2));
        repeat (extra) @(negedge clk);
        fetch_A = 1'b0; fetch_B = 1'b0;
        wait_idle();
    endtask

    task automatic do_store(input logic [ROW_W-1:0] data, input int extra);
        int lat;
        c_m[pc] = data; pc = (pc + 1) % ROWS;
        @(negedge clk);
        store_C = 1'b1; dataC_in = data;
        wait_ready(2, lat);
        check_val("lat_c", ROW_W'(lat), ROW_W'(1));
        repeat (extra) @(negedge clk);
        store_C = 1'b0;
        wait_idle();
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int lat, a0, b0, c0;
        logic [ROW_W-1:0] newrow, junk;

        // Reset state
        @(negedge clk);
        check_val("rst_ready_a", ROW_W'(fetch_A_ready), ROW_W'(0));
        check_val("rst_ready_b", ROW_W'(fetch_B_ready), ROW_W'(0));
        check_val("rst_ready_c", ROW_W'(store_C_ready), ROW_W'(0));
        check_val("rst_data_out", data_out, '0);
        check_val("rst_host_rdata", host_rdata, '0);
        check_val("rst_busy", ROW_W'(busy), ROW_W'(0));
        check_val("rst_host_err", ROW_W'(host_err), ROW_W'(0));
        check_val("rst_state", ROW_W'(dbg_state), ROW_W'(IDLE));
        rst_n = 1'b1;

        // 1: preload, 32 in-order fetches plus wrap
        for (int r = 0; r < ROWS; r++) host_write(SEL_A, r, fill(32'(r)), 1'b0);
        for (int r = 0; r < ROWS; r++) host_write(SEL_B, r, rand_row(), 1'b0);
        for (int i = 0; i <= ROWS; i++) do_fetch(1'b0, 0);

        // 2: simultaneous A and B, A first, each served once
        a0 = a_pulses; b0 = b_pulses;
        exp_q.push_back(a_m[pa]); pa = (pa + 1) % ROWS;
        exp_q.push_back(b_m[pb]); pb = (pb + 1) % ROWS;
        @(negedge clk);
        fetch_A = 1'b1; fetch_B = 1'b1;
        wait_ready(0, lat);
        check_val("lat_a_both", ROW_W'(lat), ROW_W'(2));
        fetch_A = 1'b0;
        wait_ready(1, lat);
        check_val("lat_b_after_a", ROW_W'(lat), ROW_W'(4));
        fetch_B = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check_val("a_pulse_count", ROW_W'(a_pulses - a0), ROW_W'(1));
        check_val("b_pulse_count", ROW_W'(b_pulses - b0), ROW_W'(1));

        // 3: store held for 10 cycles commits once and advances ptr_c by one
        c0 = c_pulses;
        do_store(fill(32'hDEADBEEF), 9);
        check_val("c_pulse_count", ROW_W'(c_pulses - c0), ROW_W'(1));
        host_read("c0_readback", SEL_C, 0, fill(32'hDEADBEEF));
        do_store(fill(32'hCAFEF00D), 0);
        host_read("c1_readback", SEL_C, 1, fill(32'hCAFEF00D));

        // 4: host write rejected while busy, accepted in IDLE
        newrow = rand_row();
        exp_q.push_back(b_m[pb]); pb = (pb + 1) % ROWS;
        @(negedge clk);
        fetch_B = 1'b1;
        @(negedge clk);
        check_val("busy_rd_b", ROW_W'(busy), ROW_W'(1));
        host_we = 1'b1; host_sel = SEL_A; host_addr = AW'(3); host_wdata = newrow;
        @(negedge clk);
        host_we = 1'b0; host_sel = SEL_NONE;
        check_val("host_err_busy", ROW_W'(host_err), ROW_W'(1));
        check_val("ready_b_rej", ROW_W'(fetch_B_ready), ROW_W'(1));
        fetch_B = 1'b0;
        wait_idle();
        host_read("a3_unchanged", SEL_A, 3, a_m[3]);
        host_write(SEL_A, 3, newrow, 1'b0);
        host_read("a3_updated", SEL_A, 3, newrow);
        junk = rand_row();
        host_write(SEL_C, 0, junk, 1'b1);
        host_write(SEL_NONE, 5, junk, 1'b1);
        host_read("c0_unchanged", SEL_C, 0, c_m[0]);

        // Host write colliding with a request accept in IDLE is rejected
        exp_q.push_back(a_m[pa]); pa = (pa + 1) % ROWS;
        @(negedge clk);
        fetch_A = 1'b1;
        host_we = 1'b1; host_sel = SEL_B; host_addr = AW'(2); host_wdata = junk;
        @(negedge clk);
        host_we = 1'b0; host_sel = SEL_NONE;
        check_val("host_err_accept", ROW_W'(host_err), ROW_W'(1));
        @(negedge clk);
        check_val("ready_a_collide", ROW_W'(fetch_A_ready), ROW_W'(1));
        fetch_A = 1'b0;
        wait_idle();
        host_read("b2_unchanged", SEL_B, 2, b_m[2]);

        // 5: start clears all pointers; fetches held high a while are served once
        for (int i = 0; i < 5; i++) do_fetch(1'b0, $urandom_range(0, 3));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        pa = 0; pb = 0; pc = 0;
        for (int i = 0; i < 4; i++) do_fetch(1'b0, $urandom_range(0, 2));
        do_fetch(1'b1, $urandom_range(0, 2));
        do_store(fill(32'h5A5A0001), 0);
        host_read("c0_after_start", SEL_C, 0, fill(32'h5A5A0001));

        // 6: reset during RD_A aborts the fetch
        a0 = a_pulses;
        @(negedge clk);
        fetch_A = 1'b1;
        @(negedge clk);
        check_val("busy_rd_a", ROW_W'(busy), ROW_W'(1));
        #1 rst_n = 1'b0;
        #1;
        check_val("abort_ready_a", ROW_W'(fetch_A_ready), ROW_W'(0));
        check_val("abort_data_out", data_out, '0);
        check_val("abort_busy", ROW_W'(busy), ROW_W'(0));
        fetch_A = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pa = 0; pb = 0; pc = 0;
        repeat (3) @(negedge clk);
        check_val("abort_no_pulse", ROW_W'(a_pulses - a0), ROW_W'(0));
        do_fetch(1'b0, 1);
        do_fetch(1'b1, 0);

        repeat (3) @(negedge clk);
        check_val("queue_drained", ROW_W'(exp_q.size()), ROW_W'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
